// File: rtl/recursive_and.sv
// Registered bitwise AND of two 2^S-bit operands, built by recursive halving
// down to 1-bit AND-plus-flop cells. Latency is one clock for every S.
module recursive_and #(
  parameter  int S = 3,
  localparam int W = 32'd1 << S
) (
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic [W-1:0] out,
  input  logic         clk,
  input  logic         rst
);

  localparam int H = W >> 32'd1;

  generate
    if ((S < 32'sd0) || (S > 32'sd6)) begin : g_bad_param
      $error("recursive_and: S must lie in 0..6");
    end else if (S == 32'sd0) begin : g_leaf
      logic w_and;
      logic r_out;

      assign w_and = in1[0] & in2[0];

      // Leaf flop: synchronous clear has priority over the sampled AND.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_out <= 1'b0;
        end else begin
          r_out <= w_and;
        end
      end

      assign out[0] = r_out;
    end else begin : g_split
      recursive_and #(.S(S - 32'sd1)) u_lo (
        .in1 (in1[H-1:0]),
        .in2 (in2[H-1:0]),
        .out (out[H-1:0]),
        .clk (clk),
        .rst (rst)
      );

      recursive_and #(.S(S - 32'sd1)) u_hi (
        .in1 (in1[W-1:H]),
        .in2 (in2[W-1:H]),
        .out (out[W-1:H]),
        .clk (clk),
        .rst (rst)
      );
    end
  endgenerate

endmodule

// File: tb/tb_recursive_and.sv
// Directed-vector and random bench for recursive_and at S = 0, 3, 4 and 5,
// all instances sharing clock, reset and the low bits of one operand pair.
module tb_recursive_and;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a   = 32'h0;
  logic [31:0] b   = 32'h0;

  logic [0:0]  out0;
  logic [7:0]  out3;
  logic [15:0] out4;
  logic [31:0] out5;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  recursive_and #(.S(0)) u_s0 (.in1(a[0:0]),  .in2(b[0:0]),  .out(out0), .clk(clk), .rst(rst));
  recursive_and #(.S(3)) u_s3 (.in1(a[7:0]),  .in2(b[7:0]),  .out(out3), .clk(clk), .rst(rst));
  recursive_and #(.S(4)) u_s4 (.in1(a[15:0]), .in2(b[15:0]), .out(out4), .clk(clk), .rst(rst));
  recursive_and #(.S(5)) u_s5 (.in1(a),       .in2(b),       .out(out5), .clk(clk), .rst(rst));

  typedef struct {
    logic       r;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Apply inputs at the falling edge, then return just after the next rising edge.
  task automatic step(input logic r, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    rst = r;
    a   = va;
    b   = vb;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{r: 1'b1, a: 8'hFF, b: 8'hFF, e: 8'h00};
    vecs[1] = '{r: 1'b0, a: 8'hFF, b: 8'hFF, e: 8'hFF};
    vecs[2] = '{r: 1'b0, a: 8'h80, b: 8'hFF, e: 8'h80};
    vecs[3] = '{r: 1'b0, a: 8'hAA, b: 8'h55, e: 8'h00};
    vecs[4] = '{r: 1'b0, a: 8'hF0, b: 8'h3C, e: 8'h30};
    vecs[5] = '{r: 1'b0, a: 8'hFF, b: 8'h0F, e: 8'h0F};
    vecs[6] = '{r: 1'b1, a: 8'hFF, b: 8'h0F, e: 8'h00};
    vecs[7] = '{r: 1'b0, a: 8'hFF, b: 8'h0F, e: 8'h0F};
    vecs[8] = '{r: 1'b1, a: 8'h12, b: 8'h34, e: 8'h00};
    vecs[9] = '{r: 1'b0, a: 8'h00, b: 8'hFF, e: 8'h00};

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].r, {24'h0, vecs[i].a}, {24'h0, vecs[i].b});
      check($sformatf("vec%0d_s3", i), {24'h0, out3}, {24'h0, vecs[i].e});
    end

    // Operand change between edges must not reach out until the next edge.
    step(1'b0, 32'hFF, 32'hFF);
    check("mask_pre", {24'h0, out3}, 32'hFF);
    a = 32'h80;
    #2;
    check("mask_hold", {24'h0, out3}, 32'hFF);
    @(posedge clk);
    #1;
    check("mask_post", {24'h0, out3}, 32'h80);

    // Mid-cycle glitch restored before the edge is ignored.
    step(1'b0, 32'h3C, 32'hF0);
    a = 32'h00;
    #2;
    a = 32'h3C;
    @(posedge clk);
    #1;
    check("glitch_s3", {24'h0, out3}, 32'h30);

    // S=0 leaf behaviour and one-edge latency.
    step(1'b0, 32'h1, 32'h1);
    check("s0_11", {31'h0, out0}, 32'h1);
    @(negedge clk);
    b = 32'h0;
    check("s0_hold", {31'h0, out0}, 32'h1);
    @(posedge clk);
    #1;
    check("s0_10", {31'h0, out0}, 32'h0);

    // S=5 full width, previous output was 1 & 0.
    @(negedge clk);
    a = 32'hDEADBEEF;
    b = 32'hFFFF0000;
    check("s5_hold", out5, 32'h0);
    @(posedge clk);
    #1;
    check("s5_word", out5, 32'hDEAD0000);
    check("s4_word", {16'h0, out4}, 32'h0);

    step(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("s5_rst", out5, 32'h0);
    step(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("s5_ones", out5, 32'hFFFFFFFF);

    // Random operands with occasional single-cycle reset pulses.
    for (int i = 0; i < 1000; i++) begin
      logic        r;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] exp_w;
      r     = ($urandom_range(0, 15) == 0);
      ra    = $urandom;
      rb    = $urandom;
      exp_w = r ? 32'h0 : (ra & rb);
      step(r, ra, rb);
      check($sformatf("rnd%0d_s3", i), {24'h0, out3}, {24'h0, exp_w[7:0]});
      check($sformatf("rnd%0d_s4", i), {16'h0, out4}, {16'h0, exp_w[15:0]});
    end

    rst = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
